sram_port_arbiter: RTL

Shares one synchronous SRAM port between the instruction-fetch requester and the MEM-stage data requester of the five-stage pipeline. Uses a request/addr_ok/data_ok handshake on both sides and allows one outstanding transaction at a time. A fixed-latency counter tracks the memory read latency. Sits between the pipeline top and a unified memory, so inst_sram_* and data_sram_* traffic can target a single physical RAM.

---
 rtl/sram_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between instruction fetch and MEM-stage data requests
//
// Ports:
//   clk, resetn (synchronous, active-low)
//   cancel         pipeline flush; drops the pending instruction response
//   inst_*         fetch side: req/addr in, addr_ok/data_ok/rdata out
//   data_*         data side: req/wr/wstrb/addr/wdata in, addr_ok/data_ok/rdata out
//   mem_*          SRAM port: en/wen/addr/wdata out, rdata in (valid MEM_LAT cycles after mem_en)
// Parameter MEM_LAT: SRAM read latency, 1..7.
// Macro ARB_FAIR_EN: when defined, inst wins a contested grant after data has won three
// contested grants in a row; otherwise data has strict priority.
module sram_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cancel,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_nxt;
    logic [2:0] cnt;
    logic own_inst, own_wr, drop;
    logic can_acc, gnt_inst, gnt_data, acc, last, inst_keep;
    // gating with resetn keeps the port quiet while reset is asserted
    assign can_acc = resetn && state != BUSY;
`ifdef ARB_FAIR_EN
    logic [1:0] starve;
    assign gnt_inst = can_acc && inst_req && (!data_req || starve == 2'd3);
`else
    assign gnt_inst = can_acc && inst_req && !data_req;
`endif
    assign gnt_data = can_acc && data_req && !gnt_inst;
    assign acc = gnt_inst || gnt_data;
    assign last = state == BUSY && cnt == 3'd1;
    // a cancel in the final busy cycle must still suppress the response
    assign inst_keep = last && own_inst && !(drop || cancel);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: state_nxt = acc ? BUSY : IDLE;
            BUSY: state_nxt = cnt == 3'd1 ? RESP : BUSY;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = gnt_inst;
        data_addr_ok = gnt_data;
        mem_en = acc;
        mem_wen = gnt_data && data_wr ? data_wstrb : 4'd0;
        mem_addr = gnt_data ? data_addr : gnt_inst ? inst_addr : 32'd0;
        mem_wdata = gnt_data && data_wr ? data_wdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= 3'd0;
            own_inst <= 1'b0;
            own_wr <= 1'b0;
            drop <= 1'b0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
        end else begin
            cnt <= acc ? 3'(MEM_LAT) : state == BUSY ? cnt - 3'd1 : cnt;
            if (acc) begin
                own_inst <= gnt_inst;
                own_wr <= gnt_data && data_wr;
            end
            // a new cancelled inst accept in RESP re-arms the flag that RESP would clear
            drop <= (cancel && (gnt_inst || (state == BUSY && own_inst))) || (drop && state != RESP);
            inst_data_ok <= inst_keep;
            data_data_ok <= last && !own_inst;
            if (inst_keep) inst_rdata <= mem_rdata;
            if (last && !own_inst && !own_wr) data_rdata <= mem_rdata;
        end
    end

`ifdef ARB_FAIR_EN
    always_ff @(posedge clk) begin
        if (!resetn) starve <= 2'd0;
        else if (gnt_inst) starve <= 2'd0;
        else if (gnt_data && inst_req) starve <= starve + 2'd1;
    end
`endif
endmodule
